// File: rtl/alu_vector_sequencer.sv
// alu_vector_sequencer: steps vector ops one element at a time
// through the shared scalar ALU, with MAC accumulation.
module alu_vector_sequencer #(
  parameter int MAX_LEN = 8,
  parameter int IDX_W   = 3,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [10:0]       instr,
  input  logic [IDX_W:0]    vlen,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic              issue_valid,
  output logic [IDX_W-1:0]  issue_idx,
  output logic [3:0]        alu_ctrl,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] acc_out,
  output logic              done,
  output logic              illegal
);

  localparam logic [IDX_W:0] LP_MAX = (IDX_W+1)'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_FINISH
  } state_t;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       ld;
    logic       st;
    logic       mac;
  } op_t;

  state_t            r_state;
  state_t            w_next;
  op_t               r_op;
  op_t               w_dec;
  logic              w_legal;
  logic              w_start_ok;
  logic              w_last;
  logic [IDX_W:0]    r_vlen;
  logic [IDX_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_acc;
  logic              r_illegal;

  assign acc_out = r_acc;
  assign w_last  = ({1'b0, r_cnt} == (r_vlen - 1'b1));

  // Decode the incoming opcode and qualify it with the vector length.
  always_comb begin
    w_dec   = '0;
    w_legal = 1'b1;
    case (instr)
      11'b10001010010: w_dec.ctrl = 4'b0010;
      11'b11001010010: w_dec.ctrl = 4'b0110;
      11'b10011010010: w_dec.ctrl = 4'b0100;
      11'b10001010100: w_dec.ctrl = 4'b0010;
      11'b11111010100: begin
        w_dec.ctrl = 4'b1000;
        w_dec.mac  = 1'b1;
      end
      11'b10011110000: begin
        w_dec.ctrl = 4'b0100;
        w_dec.ld   = 1'b1;
      end
      11'b10001110000: begin
        w_dec.ctrl = 4'b0010;
        w_dec.st   = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
    w_start_ok = w_legal && (vlen != '0) && (vlen <= LP_MAX);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and per-cycle output decode.
  always_comb begin
    w_next      = r_state;
    busy        = 1'b0;
    issue_valid = 1'b0;
    issue_idx   = '0;
    alu_ctrl    = 4'b0000;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = w_start_ok ? S_ISSUE : S_FINISH;
      end
      S_ISSUE: begin
        busy        = 1'b1;
        alu_ctrl    = r_op.ctrl;
        issue_idx   = r_cnt;
        mem_rd      = r_op.ld;
        mem_wr      = r_op.st;
        issue_valid = (r_op.ld || r_op.st) ? mem_ready : 1'b1;
        if (issue_valid && w_last) w_next = S_FINISH;
      end
      S_FINISH: begin
        busy    = 1'b1;
        done    = 1'b1;
        illegal = r_illegal;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the op on accepted start; step counter and accumulator per issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= '0;
      r_vlen    <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_illegal <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_op      <= w_dec;
      r_vlen    <= vlen;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_illegal <= !w_start_ok;
    end else if (issue_valid) begin
      if (r_op.mac) r_acc <= r_acc + alu_result;
      if (!w_last)  r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_vector_sequencer.sv
// tb_alu_vector_sequencer: directed steps with an issue scoreboard
// for alu_vector_sequencer.
module tb_alu_vector_sequencer;

  localparam logic [10:0] VADD = 11'b10001010010;
  localparam logic [10:0] VSUB = 11'b11001010010;
  localparam logic [10:0] VMUL = 11'b10011010010;
  localparam logic [10:0] MAC  = 11'b11111010100;
  localparam logic [10:0] VLD1 = 11'b10011110000;
  localparam logic [10:0] VST1 = 11'b10001110000;
  localparam logic [10:0] SADD = 11'b10001011000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] instr;
  logic [3:0]  vlen;
  logic        mem_ready;
  logic [31:0] alu_result;
  logic        busy;
  logic        issue_valid;
  logic [2:0]  issue_idx;
  logic [3:0]  alu_ctrl;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] acc_out;
  logic        done;
  logic        illegal;

  typedef struct {
    logic [2:0] idx;
    logic [3:0] ctrl;
  } iss_t;

  iss_t q[$];
  int   total = 0;
  int   bad   = 0;

  alu_vector_sequencer #(.MAX_LEN(8), .IDX_W(3), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .vlen(vlen), .mem_ready(mem_ready), .alu_result(alu_result),
    .busy(busy), .issue_valid(issue_valid), .issue_idx(issue_idx),
    .alu_ctrl(alu_ctrl), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .acc_out(acc_out), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] ctrl, input int n);
    iss_t e;
    for (int i = 0; i < n; i++) begin
      e.idx  = 3'(i);
      e.ctrl = ctrl;
      q.push_back(e);
    end
  endtask

  // Advance one cycle, drive this cycle's inputs, then score any issue.
  task automatic cyc(input logic st, input logic mr,
                     input logic [31:0] ar);
    iss_t e;
    @(posedge clk);
    #1;
    start      = st;
    mem_ready  = mr;
    alu_result = ar;
    #1;
    if (issue_valid) begin
      if (q.size() == 0) begin
        chk("spurious_issue", 1, 0);
      end else begin
        e = q.pop_front();
        chk("issue_idx", issue_idx, e.idx);
        chk("issue_ctrl", alu_ctrl, e.ctrl);
      end
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ctrl"}, alu_ctrl, 0);
    chk({tag, "_strb"}, {issue_valid, mem_rd, mem_wr, illegal}, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; instr = '0; vlen = '0;
    mem_ready = 1'b0; alu_result = '0;
    cyc(0, 0, 0);
    chk_quiet("rst");
    chk("rst_acc", acc_out, 0);
    chk("rst_idx", issue_idx, 0);
    reset = 1'b0;
    cyc(0, 0, 0);

    // VADD vlen=4
    instr = VADD; vlen = 4; push(4'b0010, 4);
    cyc(1, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      cyc(0, 0, 0);
      chk("vadd_busy", busy, 1);
      chk("vadd_valid", issue_valid, 1);
      chk("vadd_nodone", done, 0);
    end
    cyc(0, 0, 0);
    chk("vadd_done", done, 1);
    chk("vadd_illegal", illegal, 0);
    chk("vadd_fin_ctrl", alu_ctrl, 0);
    cyc(0, 0, 0);
    chk("vadd_idle_busy", busy, 0);
    chk("vadd_sb", q.size(), 0);

    // MAC vlen=3 with wrap
    instr = MAC; vlen = 3; push(4'b1000, 3);
    cyc(1, 0, 0);
    cyc(0, 0, 32'd5);
    chk("mac_acc0", acc_out, 0);
    cyc(0, 0, 32'd7);
    chk("mac_acc1", acc_out, 5);
    cyc(0, 0, 32'hFFFF_FFFF);
    chk("mac_acc2", acc_out, 12);
    cyc(0, 0, 0);
    chk("mac_done", done, 1);
    chk("mac_acc3", acc_out, 11);
    cyc(0, 0, 0);
    chk("mac_hold", acc_out, 11);
    chk("mac_sb", q.size(), 0);

    // VLD1 vlen=2 with a 3-cycle stall
    instr = VLD1; vlen = 2; push(4'b0100, 2);
    cyc(1, 0, 0);
    for (int c = 1; c <= 3; c++) begin
      cyc(0, 0, 0);
      chk("vld_rd", mem_rd, 1);
      chk("vld_stall_valid", issue_valid, 0);
      chk("vld_stall_idx", issue_idx, 0);
      chk("vld_stall_done", done, 0);
    end
    cyc(0, 1, 0);
    chk("vld_v0", issue_valid, 1);
    cyc(0, 1, 0);
    chk("vld_v1", issue_valid, 1);
    chk("vld_nodone", done, 0);
    cyc(0, 0, 0);
    chk("vld_done", done, 1);
    chk("vld_fin_rd", mem_rd, 0);
    cyc(0, 0, 0);
    chk("vld_sb", q.size(), 0);

    // Illegal: scalar ADD, VSUB vlen=0, VSUB vlen=9
    for (int k = 0; k < 3; k++) begin
      instr = (k == 0) ? SADD : VSUB;
      vlen  = (k == 0) ? 4'd4 : (k == 1) ? 4'd0 : 4'd9;
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      chk("ill_done", done, 1);
      chk("ill_flag", illegal, 1);
      chk("ill_valid", issue_valid, 0);
      chk("ill_acc", acc_out, 0);
      cyc(0, 0, 0);
      chk_quiet("ill_after");
    end

    // VST1 vlen=2 with start held high throughout
    instr = VST1; vlen = 2; push(4'b0010, 2);
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    chk("vst_wr", mem_wr, 1);
    cyc(1, 1, 0);
    chk("vst_valid1", issue_valid, 1);
    cyc(1, 1, 0);
    chk("vst_done", done, 1);
    chk("vst_fin_wr", mem_wr, 0);
    cyc(1, 1, 0);
    chk("vst_idle", busy, 0);
    push(4'b0010, 2);
    cyc(0, 1, 0);
    chk("vst_restart", busy, 1);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    chk("vst_done2", done, 1);
    cyc(0, 0, 0);
    chk("vst_sb", q.size(), 0);

    // Reset in the middle of VMUL vlen=8
    instr = VMUL; vlen = 8; push(4'b0100, 3);
    cyc(1, 0, 0);
    cyc(0, 0, 32'd3);
    cyc(0, 0, 32'd3);
    cyc(0, 0, 32'd3);
    chk("vmul_busy", busy, 1);
    reset = 1'b1;
    cyc(0, 0, 0);
    chk_quiet("mid_rst");
    chk("mid_rst_acc", acc_out, 0);
    chk("mid_rst_sb", q.size(), 0);
    reset = 1'b0;
    instr = VADD; vlen = 2; push(4'b0010, 2);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("post_rst_valid", issue_valid, 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("post_rst_done", done, 1);
    cyc(0, 0, 0);
    chk("post_rst_sb", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
